mega65_kbd_scanner: RTL
=======================

MEGA65_KBD_SCANNER -- requirements
Module: mega65_kbd_scanner

Interface
REQ-001 SHALL have parameter CLKDIV, default 14, meaning clk cycles per half period of kb_io0 (1 MHz at 28 MHz).
REQ-002 SHALL have parameter GAP, default 16, meaning idle bit periods between frames (sync marker).
REQ-003 clk  input  1  system clock (28 MHz); the block has one clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 kb_io0  output  1  serial clock to keyboard controller.
REQ-006 kb_io1  output  1  serial data to keyboard (LED word, sync marker).
REQ-007 kb_io2  input  1  serial key data from keyboard, active-low, asynchronous to clk.
REQ-008 led_data  input  32  LED word; latched at frame start.
REQ-009 keys  output  80  debounced matrix, 1 = pressed, index = frame bit number.
REQ-010 restore  output  1  debounced RESTORE key (frame bit 80), 1 = pressed.
REQ-011 frame_done  output  1  one-cycle pulse; new keys/restore values visible.

Function
REQ-012 SHALL pass kb_io2 through a 2-flop synchronizer before any use.
REQ-013 SHALL define a bit period as 2*CLKDIV clk cycles: kb_io0 low for the first CLKDIV cycles, high for the last CLKDIV.
REQ-014 SHALL implement two states, GAP and SHIFT, with a bit counter (0..127 in SHIFT, 0..GAP-1 in GAP) and a half-period counter (0..CLKDIV-1).
REQ-015 In GAP: kb_io0 held low, kb_io1 held high for all GAP periods; no sampling.
REQ-016 GAP -> SHIFT after period GAP-1 completes; on the transition, led_data is latched into a 32-bit shift register.
REQ-017 In SHIFT period n: kb_io1 = latched LED bit n for n<32, 0 for n>=32; kb_io1 changes only on the cycle kb_io0 goes low.
REQ-018 SHALL sample synchronized kb_io2 on the last clk cycle of the high half of period n into raw[n] (128 bits, bits 81..127 discarded).
REQ-019 SHIFT -> GAP after period 127 completes.
REQ-020 On the first clk cycle of GAP, for each bit i in 0..80: if raw[i]==prev[i], debounced[i] <= ~raw[i]; otherwise debounced[i] holds; prev <= raw.
REQ-021 keys = debounced[79:0] and restore = debounced[80], both registered; they update on the same edge that raises frame_done.
REQ-022 frame_done SHALL be high for exactly one cycle per frame and low otherwise.
REQ-023 Frame length SHALL be (128+GAP)*2*CLKDIV clk cycles (4032 at defaults).
REQ-024 A press or release SHALL be reported only after being seen identically in two consecutive frames; a single-frame glitch never changes keys.
REQ-025 led_data changes during SHIFT SHALL NOT affect the frame in progress.

Reset
REQ-026 While reset_n is low: kb_io0=0, kb_io1=1, keys=0, restore=0, frame_done=0, prev=all 1, raw=all 1, state=GAP, counters=0.
REQ-027 After reset release, the first SHIFT begins after a full GAP; reset asserted mid-frame aborts it immediately, and no partial frame updates keys.

Verification
REQ-028 Reset, kb_io2 held 1 for 3 frames -> keys=0, restore=0, frame_done pulses every 4032 cycles, kb_io0 period 28 cycles.
REQ-029 led_data=0xA5000001 at frame start, changed to 0 mid-frame -> kb_io1 in periods 0..31 = 1,0..0,1,0,1,0,0,1,0,1 (LSB first), 0 in periods 32..127, 1 throughout GAP.
REQ-030 kb_io2 low in bit 5 for one frame only -> keys stays 0; bit 5 low for two consecutive frames -> keys[5]=1 at second frame_done; bit 5 high for two frames -> keys[5]=0.
REQ-031 kb_io2 low in bit 80 and bit 120 for two frames -> restore=1, keys=0.
REQ-032 reset_n pulsed low during SHIFT period 60 with bit 5 pressed -> outputs at reset values immediately; kb_io0 low for GAP periods before the first SHIFT; keys[5]=1 only after two further full frames.

Source files
------------

// File: rtl/mega65_kbd_scanner_if.sv
// Serial link between the scanner and the MEGA65 keyboard controller:
// kb_io0 is the bit clock, kb_io1 carries LED bits and the sync gap,
// kb_io2 returns active-low key state.
interface mega65_kbd_scanner_if;
    logic kb_io0;
    logic kb_io1;
    logic kb_io2;

    modport master (
        output kb_io0,
        output kb_io1,
        input  kb_io2
    );

    modport slave (
        input  kb_io0,
        input  kb_io1,
        output kb_io2
    );
endinterface

// File: rtl/mega65_kbd_scanner.sv
// MEGA65 keyboard scanner: clocks out 128 bit periods per frame followed
// by an idle gap, samples 81 key bits and debounces them over two frames.
module mega65_kbd_scanner #(
    parameter int CLKDIV = 14,
    parameter int GAP    = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    mega65_kbd_scanner_if.master        kb,
    input  logic [31:0]                 led_data,
    output logic [79:0]                 keys,
    output logic                        restore,
    output logic                        frame_done
);
    localparam int              HW         = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [HW-1:0]   HALF_LAST  = HW'(CLKDIV - 1);
    localparam logic [6:0]      GAP_LAST   = 7'(GAP - 1);
    localparam logic [6:0]      SHIFT_LAST = 7'd127;
    localparam int              NKEYS      = 81;

    typedef enum logic {ST_GAP, ST_SHIFT} state_t;

    state_t          state_reg, state_next;
    logic [HW-1:0]   half_reg, half_next;
    logic            phase_reg, phase_next;   // 0 = low half, 1 = high half
    logic [6:0]      bit_reg, bit_next;

    logic            period_end;
    logic            start_shift;
    logic            end_shift;
    logic            sample_en;
    logic            io0_next;

    logic [1:0]      sync_reg;
    logic            io0_reg;
    logic            io1_reg;
    logic [30:0]     led_sr_reg;              // LED bits still to be sent after the current one

    logic [NKEYS-1:0] raw_reg;
    logic [NKEYS-1:0] prev_reg;
    logic [NKEYS-1:0] deb_reg;
    logic [NKEYS-1:0] deb_next;
    logic [NKEYS-1:0] sample_hit;

    assign kb.kb_io0  = io0_reg;
    assign kb.kb_io1  = io1_reg;
    assign keys       = deb_reg[79:0];
    assign restore    = deb_reg[80];

    // Two-flop synchronizer for the asynchronous key data line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], kb.kb_io2};
        end
    end

    // Frame sequencer state and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_GAP;
            half_reg  <= '0;
            phase_reg <= 1'b0;
            bit_reg   <= '0;
        end else begin
            state_reg <= state_next;
            half_reg  <= half_next;
            phase_reg <= phase_next;
            bit_reg   <= bit_next;
        end
    end

    // Next-state logic: counters run in both states, only the bit limit differs.
    always_comb begin
        state_next  = state_reg;
        half_next   = half_reg;
        phase_next  = phase_reg;
        bit_next    = bit_reg;
        period_end  = phase_reg && (half_reg == HALF_LAST);
        start_shift = 1'b0;
        end_shift   = 1'b0;
        sample_en   = 1'b0;

        if (half_reg == HALF_LAST) begin
            half_next  = '0;
            phase_next = ~phase_reg;
        end else begin
            half_next  = half_reg + 1'b1;
        end

        case (state_reg)
            ST_GAP: begin
                if (period_end) begin
                    if (bit_reg == GAP_LAST) begin
                        state_next  = ST_SHIFT;
                        bit_next    = '0;
                        start_shift = 1'b1;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                sample_en = period_end;
                if (period_end) begin
                    if (bit_reg == SHIFT_LAST) begin
                        state_next = ST_GAP;
                        bit_next   = '0;
                        end_shift  = 1'b1;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_GAP;
                bit_next   = '0;
            end
        endcase

        io0_next = (state_next == ST_SHIFT) && phase_next;
    end

    // Serial outputs: clock only toggles in SHIFT, data idles high in GAP
    // and advances exactly when the clock drops at a period boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            io0_reg    <= 1'b0;
            io1_reg    <= 1'b1;
            led_sr_reg <= '0;
        end else begin
            io0_reg <= io0_next;
            if (start_shift) begin
                io1_reg    <= led_data[0];
                led_sr_reg <= led_data[31:1];
            end else if (end_shift) begin
                io1_reg    <= 1'b1;
            end else if (sample_en) begin
                io1_reg    <= led_sr_reg[0];
                led_sr_reg <= {1'b0, led_sr_reg[30:1]};
            end
        end
    end

    // Per-bit sample decode and two-frame agreement filter.
    genvar gi;
    generate
        for (gi = 0; gi < NKEYS; gi++) begin : g_bit
            assign sample_hit[gi] = sample_en && (bit_reg == 7'(gi));
            assign deb_next[gi]   = (raw_reg[gi] == prev_reg[gi]) ? ~raw_reg[gi] : deb_reg[gi];
        end
    endgenerate

    // Capture raw key bits; bits beyond RESTORE are never stored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw_reg <= '1;
        end else begin
            raw_reg <= (raw_reg & ~sample_hit) | ({NKEYS{sync_reg[1]}} & sample_hit);
        end
    end

    // Debounce update and frame_done pulse at the start of every GAP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_reg   <= '1;
            deb_reg    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= end_shift;
            if (end_shift) begin
                deb_reg  <= deb_next;
                prev_reg <= raw_reg;
            end
        end
    end
endmodule
